fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// CPU-wide shared definitions: instruction width, reset vector and the
// fetch state machine encoding.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int FETCH_STRIDE = 4;

  // RUN fetches normally; DROP waits for one squashed in-flight response.
  typedef enum logic {
    RUN  = 1'b0,
    DROP = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Shift-register instruction buffer; entry 0 is always the head, so the
// head outputs come straight from a register.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_valid,
  output logic [WIDTH-1:0]             head_data
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] mem_n [DEPTH];
  logic             pop_eff;
  logic             push_eff;
  logic [CW-1:0]    wr_idx;

  // A pop frees the slot at the tail, so a push at full occupancy is legal.
  always_comb begin
    pop_eff  = pop && (count != '0);
    push_eff = push && ((count < CW'(DEPTH)) || pop_eff);
    wr_idx   = pop_eff ? (count - CW'(1)) : count;
    for (int i = 0; i < DEPTH; i++) mem_n[i] = mem[i];
    if (pop_eff) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem[i+1];
    end
    if (push_eff) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) mem_n[i] = push_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(push_eff) - CW'(pop_eff);
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = mem[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches with one request in
// flight, buffers returned words for decode and squashes them on redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              size     = INSTR_W,
  parameter int              DEPTH    = 2,
  parameter logic [size-1:0] RESET_PC = size'(RESET_PC_DEFAULT)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  output logic            imem_req,
  output logic [size-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [size-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [size-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [size-1:0] if_instr,
  output logic [size-1:0] if_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    state;
  logic [size-1:0] fetch_pc;
  logic [size-1:0] req_addr;
  logic            outstanding;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            req_ok;
  logic            req_fire;
  logic            push;
  logic [2*size-1:0] head_data;

  // Buffer slots are reserved at grant time, so the buffer can never overflow.
  assign occupancy = {1'b0, count} + (CW+1)'(outstanding);
  assign req_ok    = (state == RUN) && !outstanding && !redirect_valid &&
                     (occupancy < (CW+1)'(DEPTH));
  assign imem_req  = RESET_N && req_ok;
  assign imem_addr = fetch_pc;
  assign req_fire  = req_ok && imem_gnt;
  assign push      = (state == RUN) && outstanding && imem_rvalid && !redirect_valid;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      req_addr    <= '0;
      outstanding <= 1'b0;
    end else if (redirect_valid) begin
      // A response still in flight must be swallowed before fetching again.
      fetch_pc <= redirect_pc;
      if (outstanding && !imem_rvalid) begin
        state <= DROP;
      end else begin
        state       <= RUN;
        outstanding <= 1'b0;
      end
    end else begin
      case (state)
        RUN: begin
          if (imem_rvalid && outstanding) outstanding <= 1'b0;
          if (req_fire) begin
            fetch_pc    <= fetch_pc + size'(FETCH_STRIDE);
            req_addr    <= fetch_pc;
            outstanding <= 1'b1;
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            outstanding <= 1'b0;
            state       <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * size)
  ) u_fifo (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .push       (push),
    .push_data  ({imem_rdata, req_addr}),
    .pop        (if_ready),
    .flush      (redirect_valid),
    .count      (count),
    .head_valid (if_valid),
    .head_data  (head_data)
  );

  assign if_instr = head_data[2*size-1:size];
  assign if_pc    = head_data[size-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model answers grants, a monitor
// checks every decode handshake against the expected delivery queue.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int grant_cnt = 0;
  int resp_delay = 0;
  bit pending = 1'b0;
  int wait_cnt = 0;
  logic [31:0] pend_addr;

  logic [31:0] exp_addr_q [$];
  logic [63:0] exp_del_q  [$];

  fetch_unit #(
    .size     (32),
    .DEPTH    (2),
    .RESET_PC (RST_PC)
  ) dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic exp_req(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic exp_del(input logic [31:0] pc);
    exp_del_q.push_back({pc, data_of(pc)});
  endtask

  task automatic run_grants(input int n);
    int target;
    int t;
    target = grant_cnt + n;
    t = 0;
    imem_gnt = 1'b1;
    while (grant_cnt < target && t < 100) begin
      step(1);
      t++;
    end
    imem_gnt = 1'b0;
    if (grant_cnt < target) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: got %0d grants expected %0d", n - (target - grant_cnt), n);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_del_q.size() != 0 || exp_addr_q.size() != 0) && t < 60) begin
      step(1);
      t++;
    end
    check(name, 32'(exp_del_q.size() + exp_addr_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    int t;
    t = 0;
    imem_gnt = 1'b0;
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    while (pending && t < 50) begin
      step(1);
      t++;
    end
    @(posedge CLK); #3;
    RESET_N = 1'b0;
    @(posedge CLK); #3;
    RESET_N = 1'b1;
    step(1);
  endtask

  // Memory model: samples grants before the edge, answers after resp_delay cycles.
  initial begin : mem_model
    bit fire;
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge CLK);
      fire = imem_req && imem_gnt;
      a = imem_addr;
      if (fire) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_request: got addr %h expected none", a);
        end else begin
          check("req_addr", a, exp_addr_q.pop_front());
        end
      end
      @(posedge CLK); #1;
      imem_rvalid = 1'b0;
      if (fire) begin
        pending = 1'b1;
        pend_addr = a;
        wait_cnt = resp_delay;
        grant_cnt++;
      end
      if (pending) begin
        if (wait_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = data_of(pend_addr);
          pending = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge CLK);
      if (RESET_N && if_valid && if_ready) begin
        if (exp_del_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_delivery: got pc %h instr %h expected none", if_pc, if_instr);
        end else begin
          e = exp_del_q.pop_front();
          check("if_pc", if_pc, e[63:32]);
          check("if_instr", if_instr, e[31:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int g0;
    int t;
    RESET_N = 1'b1;
    imem_gnt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b0;
    #1 RESET_N = 1'b0;

    // Reset values, then the first request right after release.
    step(2);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    @(posedge CLK); #3;
    RESET_N = 1'b1;
    step(1);
    check("req_after_rst", 32'(imem_req), 32'd1);
    check("addr_after_rst", imem_addr, RST_PC);

    // Streaming fetch with latency check on the first word.
    if_ready = 1'b1;
    exp_req(32'h0); exp_req(32'h4); exp_req(32'h8); exp_req(32'hC);
    exp_del(32'h0); exp_del(32'h4); exp_del(32'h8); exp_del(32'hC);
    imem_gnt = 1'b1;
    step(1);
    check("t1_lat_cycle1", 32'(if_valid), 32'd0);
    step(1);
    check("t1_lat_valid", 32'(if_valid), 32'd1);
    check("t1_lat_pc", if_pc, 32'h0);
    check("t1_lat_instr", if_instr, data_of(32'h0));
    run_grants(3);
    drain("t1_drained");

    // Decode stalled: only DEPTH requests may be issued.
    do_reset();
    exp_req(32'h0); exp_req(32'h4);
    g0 = grant_cnt;
    imem_gnt = 1'b1;
    step(10);
    imem_gnt = 1'b0;
    check("t2_grants", 32'(grant_cnt - g0), 32'd2);
    check("t2_if_valid", 32'(if_valid), 32'd1);
    check("t2_head_pc", if_pc, 32'h0);
    exp_req(32'h8);
    exp_del(32'h0); exp_del(32'h4); exp_del(32'h8);
    if_ready = 1'b1;
    run_grants(1);
    drain("t2_drained");

    // Redirect while the fetch of 0x8 is still in flight.
    do_reset();
    if_ready = 1'b1;
    exp_req(32'h0); exp_req(32'h4);
    exp_del(32'h0); exp_del(32'h4);
    run_grants(2);
    resp_delay = 3;
    exp_req(32'h8);
    run_grants(1);
    redirect_pc = 32'h100;
    redirect_valid = 1'b1;
    #1;
    check("t3_req_on_redirect", 32'(imem_req), 32'd0);
    step(1);
    redirect_valid = 1'b0;
    #1;
    check("t3_req_in_drop", 32'(imem_req), 32'd0);
    check("t3_flushed", 32'(if_valid), 32'd0);
    resp_delay = 0;
    exp_req(32'h100);
    exp_del(32'h100);
    run_grants(1);
    drain("t3_drained");

    // Redirect in the same cycle as the response for 0x4.
    do_reset();
    if_ready = 1'b1;
    exp_req(32'h0);
    exp_del(32'h0);
    run_grants(1);
    resp_delay = 2;
    exp_req(32'h4);
    run_grants(1);
    step(2);
    redirect_pc = 32'h200;
    redirect_valid = 1'b1;
    step(1);
    redirect_valid = 1'b0;
    #1;
    check("t4_if_valid", 32'(if_valid), 32'd0);
    check("t4_req", 32'(imem_req), 32'd1);
    check("t4_addr", imem_addr, 32'h200);
    resp_delay = 0;
    exp_req(32'h200);
    exp_del(32'h200);
    run_grants(1);
    drain("t4_drained");

    // Address wrap at the top of memory.
    redirect_pc = 32'hFFFF_FFFC;
    redirect_valid = 1'b1;
    step(1);
    redirect_valid = 1'b0;
    exp_req(32'hFFFF_FFFC); exp_req(32'h0);
    exp_del(32'hFFFF_FFFC); exp_del(32'h0);
    run_grants(2);
    drain("t5_drained");

    // Reset with a request outstanding; the stale response must be ignored.
    do_reset();
    if_ready = 1'b1;
    resp_delay = 6;
    exp_req(RST_PC);
    run_grants(1);
    @(posedge CLK); #3;
    RESET_N = 1'b0;
    step(1);
    check("t6_rst_req", 32'(imem_req), 32'd0);
    check("t6_rst_valid", 32'(if_valid), 32'd0);
    @(posedge CLK); #3;
    RESET_N = 1'b1;
    t = 0;
    while (pending && t < 50) begin
      step(1);
      t++;
    end
    step(2);
    check("t6_stale_ignored", 32'(if_valid), 32'd0);
    resp_delay = 0;
    exp_req(RST_PC); exp_req(RST_PC + 32'h4);
    exp_del(RST_PC); exp_del(RST_PC + 32'h4);
    run_grants(2);
    drain("t6_drained");

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
